// File: rtl/jimmy_io_pkg.sv
// Shared types and constants for the jimmy CPU input-port peripherals.
package jimmy_io_pkg;

  localparam int WORD_W = 8;

  typedef logic [WORD_W-1:0] word_t;

  localparam word_t TERMINATOR = 8'h00;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } port_state_t;

endpackage

// File: rtl/jimmy_in_fifo_if.sv
// Producer/CPU-side bundle of jimmy_in_fifo; master drives data, strobe and clear,
// slave (the FIFO) returns ready, port data and status.
interface jimmy_in_fifo_if
  import jimmy_io_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int WIDTH = WORD_W
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] wr_data;
  logic             wr_valid;
  logic             wr_ready;
  logic             clear;
  logic             in_strobe;
  logic [WIDTH-1:0] port_data;
  logic [CNT_W-1:0] count;
  logic             empty;
  logic             full;
  logic             underflow;
  logic             overflow;

  modport master (
    output wr_data, wr_valid, clear, in_strobe,
    input  wr_ready, port_data, count, empty, full, underflow, overflow
  );

  modport slave (
    input  wr_data, wr_valid, clear, in_strobe,
    output wr_ready, port_data, count, empty, full, underflow, overflow
  );
endinterface

// File: rtl/jimmy_fifo_mem.sv
// DEPTH x WIDTH register array: one synchronous write port, one asynchronous read port.
// Contents are not reset; validity is tracked by the owner's pointers.
module jimmy_fifo_mem #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/jimmy_in_fifo.sv
// Input-port FIFO for jimmy in_port_0: head shown on port_data one clock after it lands,
// frozen while in_strobe is high, popped on the strobe's falling edge; wr_ready = !full.
module jimmy_in_fifo
  import jimmy_io_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int WIDTH = WORD_W
) (
  input  logic           clk,
  input  logic           reset,
  jimmy_in_fifo_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [PTR_W-1:0] wr_ptr, rd_ptr, rd_next;
  logic [CNT_W-1:0] count_q, count_after_pop, count_d;
  logic [WIDTH-1:0] rdata, head_d, port_q;
  logic             strobe_q, pop, pop_ok, push, empty, full;
  logic             underflow_q, overflow_q;
  port_state_t      state_q, state_d;

  always_comb begin
    empty           = (count_q == '0);
    full            = (count_q == FULL_CNT);
    push            = bus.wr_valid && !full;
    pop             = strobe_q && !bus.in_strobe;
    pop_ok          = pop && !empty;
    rd_next         = rd_ptr + PTR_W'(pop_ok);
    count_after_pop = count_q - CNT_W'(pop_ok);
    count_d         = count_after_pop + CNT_W'(push);
    // A push into a queue that is empty after the pop becomes the head before it is in memory.
    if (count_after_pop != '0) head_d = rdata;
    else if (push)             head_d = bus.wr_data;
    else                       head_d = WIDTH'(TERMINATOR);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.in_strobe)  state_d = HOLD;
      HOLD:    if (!bus.in_strobe) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Strobe tracking ignores clear so a pulse in flight still yields exactly one pop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      strobe_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      strobe_q <= bus.in_strobe;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count_q     <= '0;
      port_q      <= WIDTH'(TERMINATOR);
      underflow_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else if (bus.clear) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count_q     <= '0;
      port_q      <= WIDTH'(TERMINATOR);
      underflow_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      rd_ptr  <= rd_next;
      count_q <= count_d;
      if (state_d == IDLE) port_q <= head_d;
      if (pop && empty) underflow_q <= 1'b1;
      if (bus.wr_valid && full) overflow_q <= 1'b1;
    end
  end

  jimmy_fifo_mem #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH)
  ) u_mem (
    .clk   (clk),
    .we    (push && !bus.clear),
    .waddr (wr_ptr),
    .wdata (bus.wr_data),
    .raddr (rd_next),
    .rdata (rdata)
  );

  assign bus.wr_ready  = !full;
  assign bus.port_data = port_q;
  assign bus.count     = count_q;
  assign bus.empty     = empty;
  assign bus.full      = full;
  assign bus.underflow = underflow_q;
  assign bus.overflow  = overflow_q;
endmodule

// File: tb/tb_jimmy_in_fifo.sv
// Bench for jimmy_in_fifo: directed scenarios plus random traffic against a queue model.
module tb_jimmy_in_fifo;
  localparam int DEPTH = 16;
  localparam int WIDTH = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  jimmy_in_fifo_if #(.DEPTH(DEPTH), .WIDTH(WIDTH)) bus ();

  jimmy_in_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  // Reference model: queue contents, sticky flags, presented value, previous strobe.
  logic [WIDTH-1:0] q[$];
  logic             m_under, m_over, m_strobe_prev;
  logic [WIDTH-1:0] m_port;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_under       = 1'b0;
    m_over        = 1'b0;
    m_port        = '0;
    m_strobe_prev = 1'b0;
  endtask

  task automatic check_all(input string tag);
    check_eq({tag, ".port_data"}, 32'(bus.port_data), 32'(m_port));
    check_eq({tag, ".count"},     32'(bus.count),     q.size());
    check_eq({tag, ".empty"},     32'(bus.empty),     32'(q.size() == 0));
    check_eq({tag, ".full"},      32'(bus.full),      32'(q.size() == DEPTH));
    check_eq({tag, ".wr_ready"},  32'(bus.wr_ready),  32'(q.size() != DEPTH));
    check_eq({tag, ".underflow"}, 32'(bus.underflow), 32'(m_under));
    check_eq({tag, ".overflow"},  32'(bus.overflow),  32'(m_over));
  endtask

  // Advance the model by one rising edge using the current inputs, then compare.
  task automatic step(input string tag);
    logic pop, accept;
    if (bus.clear) begin
      q.delete();
      m_under = 1'b0;
      m_over  = 1'b0;
      m_port  = '0;
    end else begin
      pop    = m_strobe_prev && !bus.in_strobe;
      accept = bus.wr_valid && (q.size() < DEPTH);
      if (bus.wr_valid && q.size() == DEPTH) m_over = 1'b1;
      if (pop) begin
        if (q.size() == 0) m_under = 1'b1;
        else void'(q.pop_front());
      end
      if (accept) q.push_back(bus.wr_data);
      if (!bus.in_strobe) m_port = (q.size() != 0) ? q[0] : '0;
    end
    m_strobe_prev = bus.in_strobe;
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic push(input logic [WIDTH-1:0] d, input string tag);
    bus.wr_valid = 1'b1;
    bus.wr_data  = d;
    step(tag);
    bus.wr_valid = 1'b0;
  endtask

  task automatic pulse(input int hi, input int lo, input string tag);
    bus.in_strobe = 1'b1;
    repeat (hi) step(tag);
    bus.in_strobe = 1'b0;
    repeat (lo) step(tag);
  endtask

  initial begin
    logic [WIDTH-1:0] exp_seq[3];
    exp_seq[0] = 8'd3;
    exp_seq[1] = 8'd4;
    exp_seq[2] = 8'd0;
    bus.wr_data   = '0;
    bus.wr_valid  = 1'b0;
    bus.clear     = 1'b0;
    bus.in_strobe = 1'b0;
    model_reset();

    // 1: reset held for 5 cycles, then released idle
    repeat (5) @(posedge clk);
    #1;
    check_all("t1_in_reset");
    rst_n = 1'b1;
    repeat (3) step("t1_idle");
    check_eq("t1_port_zero", 32'(bus.port_data), 0);
    check_eq("t1_wr_ready", 32'(bus.wr_ready), 1);

    // 2: ordered readout 5,3,4 then terminator
    push(8'd5, "t2_push");
    push(8'd3, "t2_push");
    push(8'd4, "t2_push");
    step("t2_settle");
    check_eq("t2_head", 32'(bus.port_data), 5);
    check_eq("t2_count", 32'(bus.count), 3);
    for (int i = 0; i < 3; i++) begin
      pulse(2, 4, "t2_pulse");
      check_eq("t2_next", 32'(bus.port_data), 32'(exp_seq[i]));
      check_eq("t2_cnt", 32'(bus.count), 32'(2 - i));
    end
    check_eq("t2_underflow", 32'(bus.underflow), 0);

    // 3: fill, overflow, pop, refill, drain to 99
    for (int i = 1; i <= DEPTH; i++) push(8'(i), "t3_fill");
    bus.wr_valid = 1'b1;
    bus.wr_data  = 8'd99;
    step("t3_hold99");
    check_eq("t3_full", 32'(bus.full), 1);
    check_eq("t3_overflow", 32'(bus.overflow), 1);
    check_eq("t3_head1", 32'(bus.port_data), 1);
    bus.in_strobe = 1'b1;
    step("t3_pulse");
    step("t3_pulse");
    bus.in_strobe = 1'b0;
    step("t3_pop");
    check_eq("t3_head2", 32'(bus.port_data), 2);
    check_eq("t3_count15", 32'(bus.count), 15);
    step("t3_refill");
    bus.wr_valid = 1'b0;
    check_eq("t3_count16", 32'(bus.count), 16);
    repeat (15) pulse(1, 1, "t3_drain");
    check_eq("t3_head99", 32'(bus.port_data), 99);
    pulse(1, 1, "t3_last");

    // 4: underflow on empty, then push still visible
    bus.clear = 1'b1;
    step("t4_clear");
    bus.clear = 1'b0;
    pulse(2, 2, "t4_pulse");
    check_eq("t4_port0", 32'(bus.port_data), 0);
    check_eq("t4_underflow", 32'(bus.underflow), 1);
    push(8'd7, "t4_push");
    check_eq("t4_port7", 32'(bus.port_data), 7);
    step("t4_idle");
    check_eq("t4_sticky", 32'(bus.underflow), 1);
    bus.clear = 1'b1;
    step("t4_clear2");
    bus.clear = 1'b0;
    check_eq("t4_cleared", 32'(bus.underflow), 0);

    // 5: push during strobe does not disturb held data
    push(8'd9, "t5_push9");
    bus.in_strobe = 1'b1;
    step("t5_hold");
    push(8'd6, "t5_push6");
    check_eq("t5_hold9", 32'(bus.port_data), 9);
    step("t5_hold");
    bus.in_strobe = 1'b0;
    step("t5_fall");
    check_eq("t5_port6", 32'(bus.port_data), 6);
    check_eq("t5_count1", 32'(bus.count), 1);

    // 6: asynchronous reset between edges
    for (int i = 0; i < 5; i++) push(8'(20 + i), "t6_push");
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("t6_async");
    #3;
    @(negedge clk);
    rst_n = 1'b1;
    step("t6_release");
    check_eq("t6_port0", 32'(bus.port_data), 0);

    // random traffic
    for (int c = 0; c < 3000; c++) begin
      bus.wr_valid = ($urandom_range(0, 99) < 55);
      bus.wr_data  = 8'($urandom);
      bus.clear    = ($urandom_range(0, 99) < 2);
      if (bus.in_strobe) bus.in_strobe = ($urandom_range(0, 1) == 1);
      else               bus.in_strobe = ($urandom_range(0, 3) == 0);
      step("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
